// File: rtl/bit_serial_add_seq_pkg.sv
// Types and helpers shared by the bit-serial adder sequencer and the storage arrays beside it.
package bit_serial_add_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  // Callers cast the result down to their own word-line count.
  function automatic logic [MAX_WIDTH-1:0] onehot(input logic [31:0] idx);
    onehot = MAX_WIDTH'(1) << idx;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder with B-invert for subtraction and the registered carry between steps.
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic load_val_i,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  input  logic sub_i,
  output logic sum_o,
  output logic cout_o,
  output logic cin_o
);

  logic carry_q;
  logic b_x;

  assign b_x    = b_i ^ sub_i;
  assign sum_o  = a_i ^ b_x ^ carry_q;
  assign cout_o = (a_i & b_x) | (carry_q & (a_i ^ b_x));
  assign cin_o  = carry_q;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (load_i) begin
      carry_q <= load_val_i;
    end else if (en_i) begin
      carry_q <= cout_o;
    end
  end

endmodule

// File: rtl/bit_serial_add_seq.sv
// Sequencer that walks operand bits out of arrays A/B, adds them serially and writes result array R.
module bit_serial_add_seq
  import bit_serial_add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             to_adder_a_i,
  input  logic             to_adder_b_i,
  output logic [WIDTH-1:0] rwl_o,
  output logic [WIDTH-1:0] wwl_o,
  output logic             from_adder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d, last_eff;
  logic             sub_q, sub_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             carry_load, carry_en;
  logic             sum, cout, cin;
  logic [WIDTH-1:0] idx_oh;

  assign idx_oh = WIDTH'(onehot(32'(idx_q)));

  // A zero or oversized length means a full-width operation.
  always_comb begin
    if (len_i == '0 || int'(len_i) > WIDTH) begin
      last_eff = IDX_W'(WIDTH - 1);
    end else begin
      last_eff = IDX_W'(len_i - 1'b1);
    end
  end

  serial_fa_cell u_fa (
    .clk        (clk),
    .rst        (rst),
    .load_i     (carry_load),
    .load_val_i (sub_i),
    .en_i       (carry_en),
    .a_i        (a_q),
    .b_i        (b_q),
    .sub_i      (sub_q),
    .sum_o      (sum),
    .cout_o     (cout),
    .cin_o      (cin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      sub_q   <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    sub_d        = sub_q;
    a_d          = a_q;
    b_d          = b_q;
    co_d         = co_q;
    ov_d         = ov_q;
    carry_load   = 1'b0;
    carry_en     = 1'b0;
    rwl_o        = '0;
    wwl_o        = '0;
    from_adder_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sub_d      = sub_i;
          last_d     = last_eff;
          idx_d      = '0;
          carry_load = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        busy_o  = 1'b1;
        rwl_o   = idx_oh;
        a_d     = to_adder_a_i;
        b_d     = to_adder_b_i;
        state_d = WRITE;
      end
      WRITE: begin
        busy_o       = 1'b1;
        wwl_o        = idx_oh;
        from_adder_o = sum;
        carry_en     = 1'b1;
        if (idx_q == last_q) begin
          co_d    = cout;
          ov_d    = cin ^ cout;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = READ;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign carry_out_o = co_q;
  assign overflow_o  = ov_q;

endmodule

// File: tb/tb_bit_serial_add_seq.sv
// Self-checking bench: behaves as storage arrays A, B and R and compares against arithmetic expectations.
module tb_bit_serial_add_seq;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [LEN_W-1:0] len;
  wire              to_a;
  wire              to_b;
  logic [WIDTH-1:0] rwl;
  logic [WIDTH-1:0] wwl;
  logic             from_adder;
  logic             busy;
  logic             done;
  logic             carry_out;
  logic             overflow;

  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic [WIDTH-1:0] r_word = '0;

  int checks = 0;
  int errors = 0;

  bit_serial_add_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .sub_i        (sub),
    .len_i        (len),
    .to_adder_a_i (to_a),
    .to_adder_b_i (to_b),
    .rwl_o        (rwl),
    .wwl_o        (wwl),
    .from_adder_o (from_adder),
    .busy_o       (busy),
    .done_o       (done),
    .carry_out_o  (carry_out),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  // Storage arrays: A/B drive their bit only while a read word line is up, R stores on write word lines.
  assign to_a = (rwl != '0) ? |(rwl & a_word) : 1'bz;
  assign to_b = (rwl != '0) ? |(rwl & b_word) : 1'bz;

  always @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (wwl[i]) r_word[i] <= from_adder;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation from the IDLE cycle through done; s1/s2 are cycles at which a stray start is pulsed.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [3:0] l, input int s1, input int s2, input string tag);
    int n, mask, an, bn, sa, sb, sr, exp_res, exp_r, exp_rw, exp_ww, done_k, viol;
    logic exp_c, exp_v;
    n       = (l == 0 || int'(l) > WIDTH) ? WIDTH : int'(l);
    mask    = (1 << n) - 1;
    an      = int'(a) & mask;
    bn      = int'(b) & mask;
    sa      = (an >= (1 << (n - 1))) ? an - (1 << n) : an;
    sb      = (bn >= (1 << (n - 1))) ? bn - (1 << n) : bn;
    sr      = s ? sa - sb : sa + sb;
    exp_v   = (sr < -(1 << (n - 1))) || (sr > (1 << (n - 1)) - 1);
    exp_c   = s ? (an >= bn) : ((an + bn) >= (1 << n));
    exp_res = (s ? an - bn : an + bn) & mask;

    @(negedge clk);
    check({tag, ":idle"}, 32'({busy, done}), 32'd0);
    exp_r  = (int'(r_word) & ~mask) | exp_res;
    a_word = a;
    b_word = b;
    sub    = s;
    len    = l;
    start  = 1'b1;

    done_k = -1;
    viol   = 0;
    for (int k = 1; k <= 2 * WIDTH + 8; k++) begin
      @(negedge clk);
      if (k == s1 || k == s2) begin
        start = 1'b1;
        sub   = ~s;
        len   = 4'd3;
      end else begin
        start = 1'b0;
      end
      exp_rw = (k % 2 == 1 && k <= 2 * n - 1) ? (1 << ((k - 1) / 2)) : 0;
      exp_ww = (k % 2 == 0 && k <= 2 * n) ? (1 << ((k - 2) / 2)) : 0;
      if (rwl !== WIDTH'(exp_rw) || wwl !== WIDTH'(exp_ww) || busy !== (k <= 2 * n)) viol++;
      if (k == 1) check({tag, ":busy_rise"}, 32'(busy), 32'd1);
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    check({tag, ":done_cycle"}, 32'(done_k), 32'(2 * n + 1));
    check({tag, ":wordline_walk"}, 32'(viol), 32'd0);
    check({tag, ":result"}, 32'(r_word), 32'(exp_r));
    check({tag, ":carry_out"}, 32'(carry_out), 32'(exp_c));
    check({tag, ":overflow"}, 32'(overflow), 32'(exp_v));
  endtask

  initial begin
    int found;
    int viol;
    rst    = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    len    = '0;
    a_word = '0;
    b_word = '0;
    repeat (3) @(negedge clk);
    check("reset", 32'({rwl, wwl, from_adder, busy, done, carry_out, overflow}), 32'd0);
    rst = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, 4'd8, -1, -1, "add_35_4a");
    run_op(8'hFF, 8'h01, 1'b0, 4'd8, -1, -1, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, 4'd8, -1, -1, "add_7f_01");
    run_op(8'h10, 8'h20, 1'b1, 4'd8, -1, -1, "sub_10_20");
    run_op(8'h20, 8'h10, 1'b1, 4'd8, -1, -1, "sub_20_10");
    run_op(8'h09, 8'h08, 1'b0, 4'd4, -1, -1, "len4_09_08");
    run_op(8'h5C, 8'h33, 1'b1, 4'd0, -1, -1, "len0_sub");
    run_op(8'h81, 8'h7E, 1'b0, 4'd12, -1, -1, "len12_add");

    // Stray starts at cycle 5 and in the DONE cycle; the run_op after lands its start on cycle 18.
    run_op(8'h12, 8'h34, 1'b0, 4'd8, 5, 17, "stray_start");
    run_op(8'h56, 8'h21, 1'b1, 4'd8, -1, -1, "start_at_18");

    // Reset while bit 3 is being read.
    @(negedge clk);
    a_word = 8'hC3;
    b_word = 8'h3C;
    sub    = 1'b0;
    len    = 4'd8;
    start  = 1'b1;
    found  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rwl === 8'h08) begin
        found = 1;
        break;
      end
    end
    check("rst_mid:reached_bit3", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid:outputs", 32'({rwl, wwl, from_adder, busy, done, carry_out, overflow}), 32'd0);
    rst  = 1'b0;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("rst_mid:no_done", 32'(viol), 32'd0);
    run_op(8'h3C, 8'h4B, 1'b0, 4'd8, -1, -1, "after_reset");

    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), -1, -1, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
